// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser upload path.
// Contents: FSM state encoding for the uploader, the default sync byte,
// the standard baud divisors (50 MHz clock) that the capture stage's rate
// table also uses, and a helper that maps a rate code to its divisor.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_CSUM
  } la_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int unsigned BAUD_DIV_115200 = 434;
  localparam int unsigned BAUD_DIV_57600  = 868;
  localparam int unsigned BAUD_DIV_9600   = 5208;

  // Rate code 0/1/2 -> 115200/57600/9600 baud.
  function automatic int unsigned baud_div_for(input logic [1:0] rate_sel);
    case (rate_sel)
      2'd1:    return BAUD_DIV_57600;
      2'd2:    return BAUD_DIV_9600;
      default: return BAUD_DIV_115200;
    endcase
  endfunction

endpackage

// File: rtl/la_uart_tx_byte.sv
// 8N1 byte serializer, LSB first, idle high.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   tx_start     - load tx_data; honoured only while tx_busy is low
//   tx_data[7:0] - byte to send
//   tx_done      - one-cycle pulse in the last clock of the stop bit
//   tx_busy      - high from the cycle after tx_start through the stop bit
//   uart_tx      - serial line
// The start bit appears on the line the cycle after tx_start; each bit lasts
// BAUD_DIV clocks, so a byte occupies exactly 10*BAUD_DIV clocks.
module la_uart_tx_byte
  import la_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam logic [12:0] BAUD_LAST = 13'(BAUD_DIV - 1);

  logic [12:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift_q;
  logic        bit_end;

  assign bit_end = (baud_cnt == 13'd0);
  assign tx_done = tx_busy && bit_end && (bit_cnt == 4'd9);

  // shift_q holds the remaining data bits with the stop bit on top, so the
  // ninth shift naturally presents the stop level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        uart_tx  <= 1'b0;
        baud_cnt <= BAUD_LAST;
        bit_cnt  <= 4'd0;
        shift_q  <= {1'b1, tx_data};
      end
    end else if (bit_end) begin
      if (bit_cnt == 4'd9) begin
        tx_busy <= 1'b0;
        uart_tx <= 1'b1;
      end else begin
        bit_cnt  <= bit_cnt + 4'd1;
        uart_tx  <= shift_q[0];
        shift_q  <= {1'b1, shift_q[8:1]};
        baud_cnt <= BAUD_LAST;
      end
    end else begin
      baud_cnt <= baud_cnt - 13'd1;
    end
  end

endmodule

// File: rtl/la_uart_uploader.sv
// Drains the capture FIFO and sends framed packets over the UART:
//   SYNC_BYTE, seq, PKT_LEN payload bytes, checksum (8-bit sum of seq+payload).
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   enable          - permits starting a packet (sampled in IDLE only)
//   flush           - pads the open packet with 8'h00 while the FIFO is empty
//   fifo_empty      - capture FIFO empty flag
//   fifo_rdata[7:0] - FIFO data, valid the cycle after fifo_ren
//   fifo_ren        - one-cycle FIFO read strobe
//   uart_tx         - serial out, 8N1
//   busy            - FSM not in IDLE
//   pkt_cnt[15:0]   - packets completed since reset (wrapping)
//
// state | meaning
// IDLE  | waiting for enable with data in the FIFO
// SYNC  | sending the sync byte
// SEQ   | sending the sequence number
// FETCH | waiting for a payload byte (FIFO data or flush padding)
// LATCH | capturing fifo_rdata after the read strobe
// SEND  | sending one payload byte
// CSUM  | sending the checksum
module la_uart_uploader
  import la_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_115200,
  parameter int unsigned PKT_LEN   = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        flush,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rdata,
  output logic        fifo_ren,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam logic [7:0] PKT_LEN_B = 8'(PKT_LEN);

  la_state_t  state, state_nxt;
  logic [7:0] seq, csum, pay_cnt, data_q, tx_data;
  logic       tx_start, tx_done, tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable && !fifo_empty) state_nxt = ST_SYNC;
      ST_SYNC:  if (tx_done) state_nxt = ST_SEQ;
      ST_SEQ:   if (tx_done) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (!fifo_empty) state_nxt = ST_LATCH;
        else if (flush)  state_nxt = ST_SEND;
      end
      ST_LATCH: state_nxt = ST_SEND;
      ST_SEND:  if (tx_done) state_nxt = (pay_cnt == PKT_LEN_B) ? ST_CSUM : ST_FETCH;
      ST_CSUM:  if (tx_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // In a transmit state the serializer is idle only in the first cycle,
  // so !tx_busy marks exactly one launch per byte.
  always_comb begin
    busy     = (state != ST_IDLE);
    fifo_ren = (state == ST_FETCH) && !fifo_empty;
    tx_start = 1'b0;
    tx_data  = SYNC_BYTE;
    case (state)
      ST_SYNC: begin tx_start = !tx_busy; tx_data = SYNC_BYTE; end
      ST_SEQ:  begin tx_start = !tx_busy; tx_data = seq;       end
      ST_SEND: begin tx_start = !tx_busy; tx_data = data_q;    end
      ST_CSUM: begin tx_start = !tx_busy; tx_data = csum;      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq     <= '0;
      csum    <= '0;
      pay_cnt <= '0;
      data_q  <= '0;
      pkt_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (state_nxt == ST_SYNC) begin
          csum    <= '0;
          pay_cnt <= '0;
        end
        ST_SEQ:   if (tx_start) csum <= csum + seq;
        ST_FETCH: if (fifo_empty && flush) data_q <= '0;
        ST_LATCH: data_q <= fifo_rdata;
        ST_SEND:  if (tx_start) begin
          csum    <= csum + data_q;
          pay_cnt <= pay_cnt + 8'd1;
        end
        ST_CSUM:  if (tx_done) begin
          seq     <= seq + 8'd1;
          pkt_cnt <= pkt_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  la_uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .tx_busy  (tx_busy),
    .uart_tx  (uart_tx)
  );

endmodule

// File: tb/tb_la_uart_uploader.sv
// Directed bench for la_uart_uploader with BAUD_DIV=4, PKT_LEN=4.
// A FIFO model feeds the DUT; a line receiver decodes uart_tx and compares
// every byte against a queue of expected bytes filled by the stimulus.
module tb_la_uart_uploader;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_ren;
  logic        uart_tx;
  logic        busy;
  logic [15:0] pkt_cnt;

  la_uart_uploader #(
    .BAUD_DIV  (4),
    .PKT_LEN   (4),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: written by the stimulus, popped on fifo_ren.
  logic [7:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int ren_cnt = 0;
  int ren_bad = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_ren) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
      ren_cnt    <= ren_cnt + 1;
      if (fifo_empty) ren_bad <= ren_bad + 1;
    end
  end

  task automatic fifo_push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  // Scoreboard of expected wire bytes.
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq = 8'h00;

  task automatic exp_packet(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
    logic [7:0] cs;
    cs = exp_seq + p0 + p1 + p2 + p3;
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_seq);
    exp_q.push_back(p0);
    exp_q.push_back(p1);
    exp_q.push_back(p2);
    exp_q.push_back(p3);
    exp_q.push_back(cs);
    exp_seq = exp_seq + 8'd1;
  endtask

  // Line receiver: samples every negedge; a frame is 40 samples starting at
  // the first low sample. Each bit must hold its level for all 4 samples.
  logic [39:0] smp;
  logic [7:0]  rx_b;
  logic        rx_abort;
  logic        rx_ok;
  logic        lvl;

  always begin : rx
    @(negedge clk);
    if (rst_n && uart_tx === 1'b0) begin
      smp      = '0;
      rx_abort = 1'b0;
      for (int k = 1; k < 40; k++) begin
        @(negedge clk);
        if (!rst_n) begin
          rx_abort = 1'b1;
          break;
        end
        smp[k] = uart_tx;
      end
      if (!rx_abort) begin
        rx_ok = 1'b1;
        for (int j = 0; j < 10; j++) begin
          lvl = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : smp[4*j+2];
          for (int s = 0; s < 4; s++)
            if (smp[4*j+s] !== lvl) rx_ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) rx_b[i] = smp[4*(i+1)+2];
        chk("frame_40clk", {31'd0, rx_ok}, 32'd1);
        chk("rx_expected_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("rx_byte", {24'd0, rx_b}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, n < budget}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    enable  = 1'b0;
    flush   = 1'b0;
    exp_seq = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int r0;
  int n;
  int hi_cnt;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    flush  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_fifo_ren", {31'd0, fifo_ren}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic packet, plus IDLE->SYNC start-bit latency.
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33); fifo_push(8'h44);
    exp_packet(8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("sync_busy_rise", {31'd0, busy}, 32'd1);
    chk("sync_pre_start", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    chk("sync_start_bit", {31'd0, uart_tx}, 32'd0);
    wait_drain("basic_done", 2000);
    chk("basic_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    chk("basic_ren_cnt", ren_cnt, 32'd4);
    enable = 1'b0;

    // Enable drop during the seq byte: one packet only, FIFO left non-empty.
    fifo_push(8'h05); fifo_push(8'h06); fifo_push(8'h07); fifo_push(8'h08);
    fifo_push(8'h01); fifo_push(8'h01);
    exp_packet(8'h05, 8'h06, 8'h07, 8'h08);
    enable = 1'b1;
    repeat (60) @(negedge clk);
    enable = 1'b0;
    wait_drain("endrop_done", 2000);
    repeat (100) @(negedge clk);
    chk("endrop_busy", {31'd0, busy}, 32'd0);
    chk("endrop_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
    chk("endrop_fifo_left", {31'd0, fifo_empty}, 32'd0);

    // Sequence wrap: 257 packets of 8'h01 (two bytes already in the FIFO).
    do_reset();
    for (int i = 0; i < 257 * 4 - 2; i++) fifo_push(8'h01);
    for (int i = 0; i < 257; i++) exp_packet(8'h01, 8'h01, 8'h01, 8'h01);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    wait_drain("wrap_done", 90000);
    chk("wrap_pkt_cnt", {16'd0, pkt_cnt}, 32'd257);
    enable = 1'b0;

    // Starvation: two bytes, 500 idle clocks, then two more.
    do_reset();
    fifo_push(8'h10); fifo_push(8'h20);
    exp_packet(8'h10, 8'h20, 8'h30, 8'h40);
    r0 = ren_cnt;
    enable = 1'b1;
    repeat (200) @(negedge clk);
    chk("starve_ren_two", ren_cnt - r0, 32'd2);
    hi_cnt = 0;
    r0 = ren_cnt;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b1) hi_cnt++;
    end
    chk("starve_line_idle", hi_cnt, 32'd500);
    chk("starve_no_ren", ren_cnt - r0, 32'd0);
    fifo_push(8'h30);
    @(negedge clk);
    chk("fetch_lat_c1", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    chk("fetch_lat_c2", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    chk("fetch_lat_c3", {31'd0, uart_tx}, 32'd0);
    fifo_push(8'h40);
    wait_drain("starve_done", 2000);
    chk("starve_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    enable = 1'b0;

    // Flush: one real byte, three pad bytes.
    do_reset();
    fifo_push(8'h55);
    exp_packet(8'h55, 8'h00, 8'h00, 8'h00);
    r0 = ren_cnt;
    flush  = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    wait_drain("flush_done", 2000);
    chk("flush_ren_cnt", ren_cnt - r0, 32'd1);
    chk("flush_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    enable = 1'b0;
    flush  = 1'b0;

    // Reset during payload bit 3 (byte 8'h54 has d3=0, so the line is low).
    fifo_push(8'h54); fifo_push(8'hCD); fifo_push(8'hEF); fifo_push(8'h12);
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_seq);
    r0 = ren_cnt;
    enable = 1'b1;
    n = 0;
    while (ren_cnt == r0 && n < 2000) begin @(negedge clk); n++; end
    chk("rstmid_ren_seen", {31'd0, n < 2000}, 32'd1);
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("rstmid_start_seen", {31'd0, n < 20}, 32'd1);
    repeat (17) @(negedge clk);
    chk("rstmid_line_d3", {31'd0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    chk("rstmid_fifo_ren", {31'd0, fifo_ren}, 32'd0);
    chk("rstmid_q_empty", exp_q.size(), 32'd0);
    exp_seq = 8'h00;
    fifo_push(8'h34);
    exp_packet(8'hCD, 8'hEF, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wait_drain("rstmid_next_done", 2000);
    chk("rstmid_next_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    enable = 1'b0;

    repeat (5) @(negedge clk);
    chk("ren_while_empty", ren_bad, 32'd0);
    chk("fifo_drained", {31'd0, fifo_empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
